cla_sum_pipe: RTL and testbench

- Two-stage pipelined 16-bit carry-lookahead adder/subtractor. It sits directly downstream of the generate/propagate tree stage.
- Consumes operand pairs through a valid/ready handshake. Stage 1 forms bitwise and 4-bit-group generate/propagate terms. Stage 2 resolves lookahead carries and produces sum and flags.
- Feeds the lab ALU result mux and accepts one operation per cycle under no backpressure.

---
 rtl/cla_sum_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_cla_sum_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sum_pipe.sv
// cla_sum_pipe: two-stage pipelined 16-bit carry-lookahead adder/subtractor.
// Stage 1 forms bitwise and 4-bit group generate/propagate terms. Stage 2
// resolves the group carries with two-level lookahead from c0, ripples
// inside each group, and registers sum, cout, ovf and zero.
// The valid/ready handshake sustains one operation per cycle. in_ready is
// combinational from out_ready, so a drained output frees the pipe within
// the same cycle.
module cla_sum_pipe #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NGRP = WIDTH / GROUP;
   // Generate bits kept per group. The top generate bit of each group only
   // feeds that group's G term, so it is folded into G and not stored.
   localparam int GL   = GROUP - 1;

   // Group generate: G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      grp_gen = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Group propagate: P = p3 & p2 & p1 & p0.
   function automatic logic grp_prop(input logic [3:0] p);
      grp_prop = &p;
   endfunction

   // Two-level lookahead. Every group carry is expanded directly from c0,
   // so no carry ripples from one group to the next.
   // Returns {c16, c12, c8, c4, c0}.
   function automatic logic [4:0] grp_carries(input logic [3:0] gg,
                                              input logic [3:0] gp,
                                              input logic       c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = gg[0]
           | (gp[0] & c0);
      c[2] = gg[1]
           | (gp[1] & gg[0])
           | (gp[1] & gp[0] & c0);
      c[3] = gg[2]
           | (gp[2] & gg[1])
           | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & c0);
      c[4] = gg[3]
           | (gp[3] & gg[2])
           | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0])
           | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
      grp_carries = c;
   endfunction

   // Handshake and advance control
   logic s1_adv;
   logic s2_adv;
   logic in_fire;

   // Stage 1 registers
   logic                 vld_p1_q;
   logic [NGRP*GL-1:0]   gl_p1_q;
   logic [WIDTH-1:0]     p_p1_q;
   logic [NGRP-1:0]      gg_p1_q;
   logic [NGRP-1:0]      gp_p1_q;
   logic                 c0_p1_q;

   // Stage 1 next-state terms
   logic [WIDTH-1:0]     bb;
   logic [WIDTH-1:0]     g_d;
   logic [WIDTH-1:0]     p_d;
   logic [NGRP*GL-1:0]   gl_d;
   logic [NGRP-1:0]      gg_d;
   logic [NGRP-1:0]      gp_d;
   logic                 c0_d;

   // Stage 2 registers
   logic                 vld_p2_q;
   logic [WIDTH-1:0]     sum_p2_q;
   logic                 cout_p2_q;
   logic                 ovf_p2_q;
   logic                 zero_p2_q;

   // Stage 2 next-state terms
   logic [NGRP:0]        gc;
   logic [WIDTH:0]       c_all;
   logic [WIDTH-1:0]     sum_d;
   logic                 cout_d;
   logic                 ovf_d;
   logic                 zero_d;

   // Advance chain: a stage may load when it is empty or the stage after it moves.
   always_comb begin
      s2_adv  = ~vld_p2_q | out_ready;
      s1_adv  = ~vld_p1_q | s2_adv;
      in_fire = in_valid & s1_adv;
   end

   assign in_ready  = s1_adv;
   assign out_valid = vld_p2_q;
   assign sum       = sum_p2_q;
   assign cout      = cout_p2_q;
   assign ovf       = ovf_p2_q;
   assign zero      = zero_p2_q;

   // ---------------- stage 1: operand conditioning and g/p terms ----------------

   // Invert B for subtract, force carry-in, form bit and group generate/propagate.
   always_comb begin
      bb   = b ^ {WIDTH{sub}};
      c0_d = sub | cin;
      g_d  = a & bb;
      p_d  = a ^ bb;
      gl_d = '0;
      gg_d = '0;
      gp_d = '0;
      for (int k = 0; k < NGRP; k++) begin
         gl_d[k*GL +: GL] = g_d[k*GROUP +: GL];
         gg_d[k]          = grp_gen(g_d[k*GROUP +: GROUP], p_d[k*GROUP +: GROUP]);
         gp_d[k]          = grp_prop(p_d[k*GROUP +: GROUP]);
      end
   end

   // Stage 1 occupancy: set on accept, cleared when its contents move on.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
      end else if (in_fire) begin
         vld_p1_q <= 1'b1;
      end else if (s2_adv) begin
         vld_p1_q <= 1'b0;
      end
   end

   // Stage 1 data: captured only on an accepted transfer, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gl_p1_q <= '0;
         p_p1_q  <= '0;
         gg_p1_q <= '0;
         gp_p1_q <= '0;
         c0_p1_q <= 1'b0;
      end else if (in_fire) begin
         gl_p1_q <= gl_d;
         p_p1_q  <= p_d;
         gg_p1_q <= gg_d;
         gp_p1_q <= gp_d;
         c0_p1_q <= c0_d;
      end
   end

   // ---------------- stage 2: carry resolution, sum and flags ----------------

   // Lookahead group carries, short in-group ripple, then sum and flags.
   always_comb begin
      gc    = grp_carries(gg_p1_q, gp_p1_q, c0_p1_q);
      c_all = '0;
      for (int k = 0; k < NGRP; k++) begin
         c_all[k*GROUP] = gc[k];
         for (int i = 1; i < GROUP; i++) begin
            c_all[k*GROUP+i] = gl_p1_q[k*GL+i-1]
                             | (p_p1_q[k*GROUP+i-1] & c_all[k*GROUP+i-1]);
         end
      end
      c_all[WIDTH] = gc[NGRP];
      sum_d  = p_p1_q ^ c_all[WIDTH-1:0];
      cout_d = c_all[WIDTH];
      ovf_d  = c_all[WIDTH] ^ c_all[WIDTH-1];
      zero_d = ~|sum_d;
   end

   // Stage 2 registers move whenever the output side can take them; this
   // keeps the result bit-stable during a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2_q  <= 1'b0;
         sum_p2_q  <= '0;
         cout_p2_q <= 1'b0;
         ovf_p2_q  <= 1'b0;
         zero_p2_q <= 1'b0;
      end else if (s2_adv) begin
         vld_p2_q  <= vld_p1_q;
         sum_p2_q  <= sum_d;
         cout_p2_q <= cout_d;
         ovf_p2_q  <= ovf_d;
         zero_p2_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_cla_sum_pipe.sv
// Self-checking bench for cla_sum_pipe: directed vector table, reset and
// backpressure sequences, and a randomized stream against an arithmetic model.
module tb_cla_sum_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cla_sum_pipe #(.WIDTH(16), .GROUP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {cout, ovf, zero, sum}.
   function automatic logic [18:0] ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rcin, input logic rsub);
      int ua, ub, sa, sb, ures, sres;
      logic [15:0] s;
      logic        co, ov;
      ua = int'(ra);
      ub = int'(rb);
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (rsub) begin
         ures = ua - ub;
         sres = sa - sb;
         co   = (ua >= ub);
      end else begin
         ures = ua + ub + int'(rcin);
         sres = sa + sb + int'(rcin);
         co   = (ures >= 65536);
      end
      s  = 16'(ures);
      ov = (sres > 32767) || (sres < -32768);
      return {co, ov, (s == 16'h0000), s};
   endfunction

   task automatic run_vec(input vec_t v, input int n);
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", n), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_sum", n),   32'(sum),  32'(v.s));
      chk($sformatf("vec%0d_cout", n),  32'(cout), 32'(v.co));
      chk($sformatf("vec%0d_ovf", n),   32'(ovf),  32'(v.ov));
      chk($sformatf("vec%0d_zero", n),  32'(zero), 32'(v.z));
   endtask

   localparam int NOPS   = 10000;
   localparam int BUDGET = 60000;

   initial begin
      vec_t        vt[10];
      logic [18:0] q[$];
      logic [18:0] expv;
      logic [18:0] hold_val;
      logic        hold_pending;
      logic [15:0] bp_vals[4];
      int          bp_cyc[4];
      int          acc, nout, sent, got, cyc;

      //               a         b        cin   sub   sum       co    ov    z
      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vt[3] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vt[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      vt[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      vt[8] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
      vt[9] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_flags",     32'({cout, ovf, zero}), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 10; i++) run_vec(vt[i], i);

      // Backpressure: four ops, output stalled for the first six cycles
      @(negedge clk);
      acc = 0; nout = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         in_valid  = (acc < 4);
         a         = 16'(2*acc + 1);
         b         = 16'(2*acc + 2);
         cin       = 1'b0;
         sub       = 1'b0;
         out_ready = (c >= 6);
         #1;
         if (c == 3) begin
            chk("bp_hold_valid_early", 32'(out_valid), 32'd1);
            chk("bp_hold_sum_early",   32'(sum),       32'h3);
         end
         if (c == 5) begin
            chk("bp_accepts",     32'(acc),       32'd2);
            chk("bp_in_ready",    32'(in_ready),  32'd0);
            chk("bp_hold_valid",  32'(out_valid), 32'd1);
            chk("bp_hold_sum",    32'(sum),       32'h3);
         end
         if (out_valid && out_ready) begin
            if (nout < 4) begin
               bp_vals[nout] = sum;
               bp_cyc[nout]  = c;
            end
            nout++;
         end
         if (in_valid && in_ready) acc++;
      end
      in_valid = 1'b0;
      chk("bp_out_count", 32'(nout), 32'd4);
      if (nout >= 4) begin
         chk("bp_res0", 32'(bp_vals[0]), 32'h3);
         chk("bp_res1", 32'(bp_vals[1]), 32'h7);
         chk("bp_res2", 32'(bp_vals[2]), 32'hB);
         chk("bp_res3", 32'(bp_vals[3]), 32'hF);
         chk("bp_back_to_back", 32'(bp_cyc[3] - bp_cyc[0]), 32'd3);
      end

      // Reset mid-stream: fill both stages, then pulse reset with a pending input
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 16'h0300; b = 16'h0400;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_full_in_ready",  32'(in_ready),  32'd0);
      chk("mid_full_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a = 16'h0055; b = 16'h0011;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum",       32'(sum),       32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      nout = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid) nout++;
      end
      chk("mid_rst_no_stale", 32'(nout), 32'd0);

      // Randomized stream with random input gaps and output stalls
      sent = 0; got = 0; cyc = 0; hold_pending = 1'b0; hold_val = '0;
      while ((got < NOPS) && (cyc < BUDGET)) begin
         @(negedge clk);
         cyc++;
         in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (hold_pending)
            chk("rand_stall_hold", 32'({out_valid, cout, ovf, zero, sum}), 32'({1'b1, hold_val}));
         hold_pending = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rand_spurious_out", 32'd1, 32'd0);
            end else begin
               expv = q.pop_front();
               chk("rand_result", 32'({cout, ovf, zero, sum}), 32'(expv));
            end
            got++;
         end else if (out_valid) begin
            hold_pending = 1'b1;
            hold_val     = {cout, ovf, zero, sum};
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_model(a, b, cin, sub));
            sent++;
         end
      end
      in_valid = 1'b0;
      chk("rand_count",       32'(got),      32'(NOPS));
      chk("rand_queue_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
